// File: rtl/mbledhesi_serial_ctrl.sv
// ----------------------------------------------------------------------------
// mbledhesi_serial_ctrl
//
// Bit-serial ADD/SUB sequencer. A single full-adder cell is reused over WIDTH
// clock cycles, LSB first, to build a WIDTH-bit sum or difference plus flags.
// Intended as the low-area arithmetic path beside the CPU datapath.
// Subtraction is computed as A + ~B + 1: B is inverted on capture and the
// carry register is preloaded with 1.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      request; sampled only in IDLE or DONE
//   op        in   1      0 = A+B, 1 = A-B
//   a         in   WIDTH  operand A, captured on the accepting edge
//   b         in   WIDTH  operand B, captured on the accepting edge
//   busy      out  1      high while an operation is running
//   done      out  1      one-cycle pulse; result/flags updated this cycle
//   result    out  WIDTH  last completed sum/difference
//   cout      out  1      final carry (SUB: 1 = no borrow)
//   overflow  out  1      signed two's-complement overflow of last op
//   zero      out  1      high when result == 0
// ----------------------------------------------------------------------------
module mbledhesi_serial_ctrl #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_final;
    logic             carry;
    logic             a_msb;
    logic             b_msb;     // MSB of B as fed to the cell (inverted for SUB)
    logic [CNT_W-1:0] cnt;

    logic             cell_sum;
    logic             cell_cout;

    // The shared one-bit full-adder cell.
    assign cell_sum  = a_sh[0] ^ b_sh[0] ^ carry;
    assign cell_cout = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    // Result as it will look once the current sum bit is shifted in; on the
    // last bit this is the complete answer.
    assign r_final  = {cell_sum, r_sh[WIDTH-1:1]};
    assign last_bit = (state == S_RUN) && (cnt == LAST);

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == LAST) state_next = S_DONE;
            end
            S_DONE: begin
                // Back-to-back acceptance: no idle cycle between operations.
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: the datapath registers are few and are all reset, so an abort
    // mid-operation leaves no stale shift or flag state behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            carry    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= op ? ~b : b;
            carry <= op;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= op ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (state == S_RUN) begin
            r_sh  <= r_final;
            carry <= cell_cout;
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            cnt   <= cnt + CNT_W'(1);
            // Visible outputs change only on the edge that completes the op.
            if (last_bit) begin
                result   <= r_final;
                cout     <= cell_cout;
                overflow <= (a_msb == b_msb) && (cell_sum != a_msb);
                zero     <= (r_final == '0);
            end
        end
    end

endmodule
